// File: rtl/gate_test_pkg.sv
// Shared constants for the gate-under-test sequencer: FSM encoding, vector geometry, truth tables.
// Latency: n/a (constants and a helper function only).
// Backpressure: n/a.
package gate_test_pkg;

  // FSM state encoding (3-bit, plain constants so older tools can read them)
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_APPLY = 3'd1;
  localparam logic [2:0] ST_CHECK = 3'd2;
  localparam logic [2:0] ST_HOLD  = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  // A two-input gate has four input vectors, indexed by {a,b}
  localparam int VEC_W   = 2;
  localparam int NUM_VEC = 4;

  // Expected y per vector index; bit i is the output for {a,b} == i
  localparam logic [NUM_VEC-1:0] TT_AND  = 4'b1000;
  localparam logic [NUM_VEC-1:0] TT_OR   = 4'b1110;
  localparam logic [NUM_VEC-1:0] TT_NAND = 4'b0111;
  localparam logic [NUM_VEC-1:0] TT_NOR  = 4'b0001;
  localparam logic [NUM_VEC-1:0] TT_XOR  = 4'b0110;

  // Larger of two cycle counts, used to size the shared step timer
  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/step_timer.sv
// Loadable down-counter shared by the settle and display-hold phases of the sequencer.
// Latency: expired rises load_value+1 cycles after the load cycle (load N-1 -> N cycles of count).
// Backpressure: none; load always wins, counter parks at zero until reloaded.
module step_timer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic             expired
);

  logic [WIDTH-1:0] r_count;

  // Count down from the loaded value and stop at zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (load) begin
      r_count <= load_value;
    end else if (r_count != '0) begin
      r_count <= r_count - WIDTH'(1);
    end
  end

  assign expired = (r_count == '0);

endmodule

// File: rtl/gate_test_sequencer.sv
// Walks {a,b} through 00..11 on a two-input gate-under-test, samples y after settling, latches a verdict.
// Latency: launch to verdict = 1 + 4*(SETTLE_CYCLES+1+STEP_CYCLES) cycles.
// Backpressure: none; start is edge-detected and ignored while a run is in progress.
module gate_test_sequencer
  import gate_test_pkg::*;
#(
  parameter logic [NUM_VEC-1:0] EXPECTED      = TT_AND,
  parameter int                 SETTLE_CYCLES = 2,
  parameter int                 STEP_CYCLES   = 12_000_000,
  parameter bit                 CONTINUOUS    = 1'b0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               gut_y,
  output logic               gut_a,
  output logic               gut_b,
  output logic               busy,
  output logic               result_valid,
  output logic               result_pass,
  output logic [NUM_VEC-1:0] result_fail_mask,
  output logic               led_pass,
  output logic               led_fail,
  output logic [VEC_W-1:0]   led_vec
);

  // One timer serves both phases, so size it for the longer of the two
  localparam int TMR_MAX = max_int(SETTLE_CYCLES, STEP_CYCLES);
  localparam int TW      = $clog2(TMR_MAX) + 1;

  localparam logic [TW-1:0]    SETTLE_LD = TW'(SETTLE_CYCLES - 1);
  localparam logic [TW-1:0]    STEP_LD   = TW'(STEP_CYCLES - 1);
  localparam logic [VEC_W-1:0] LAST_IDX  = VEC_W'(NUM_VEC - 1);

  // Architectural state
  logic [2:0]         r_state;
  logic [VEC_W-1:0]   r_idx;
  logic [NUM_VEC-1:0] r_acc;
  logic               r_start_q;
  logic               r_valid;
  logic               r_pass;
  logic [NUM_VEC-1:0] r_mask;

  // Next-state and control wires
  logic [2:0]         w_state_nxt;
  logic [VEC_W-1:0]   w_idx_nxt;
  logic [NUM_VEC-1:0] w_acc_nxt;
  logic               w_tmr_load;
  logic [TW-1:0]      w_tmr_val;
  logic               w_tmr_expired;
  logic               w_launch;
  logic               w_done_entry;

  // Rising edge of the (already debounced) start level
  assign w_launch = start & ~r_start_q;

  step_timer #(
    .WIDTH (TW)
  ) u_step_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (w_tmr_load),
    .load_value (w_tmr_val),
    .expired    (w_tmr_expired)
  );

  // Sequencing: pick the next state, vector index, timer reload and accumulator update
  always_comb begin
    w_state_nxt  = r_state;
    w_idx_nxt    = r_idx;
    w_acc_nxt    = r_acc;
    w_tmr_load   = 1'b0;
    w_tmr_val    = SETTLE_LD;
    w_done_entry = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (w_launch) begin
          w_state_nxt = ST_APPLY;
          w_idx_nxt   = '0;
          w_acc_nxt   = '0;
          w_tmr_load  = 1'b1;
          w_tmr_val   = SETTLE_LD;
        end
      end

      ST_APPLY: begin
        // Vector is on the GUT inputs; wait for it to settle
        if (w_tmr_expired) begin
          w_state_nxt = ST_CHECK;
        end
      end

      ST_CHECK: begin
        // The only cycle in which gut_y is looked at
        w_acc_nxt[r_idx] = gut_y ^ EXPECTED[r_idx];
        w_state_nxt      = ST_HOLD;
        w_tmr_load       = 1'b1;
        w_tmr_val        = STEP_LD;
      end

      ST_HOLD: begin
        // Keep the vector on the LEDs long enough for a person to read it
        if (w_tmr_expired) begin
          if (r_idx != LAST_IDX) begin
            w_state_nxt = ST_APPLY;
            w_idx_nxt   = r_idx + VEC_W'(1);
            w_tmr_load  = 1'b1;
            w_tmr_val   = SETTLE_LD;
          end else begin
            w_state_nxt  = ST_DONE;
            w_done_entry = 1'b1;
          end
        end
      end

      ST_DONE: begin
        // Index stays at the last vector until a new run begins
        if (CONTINUOUS || w_launch) begin
          w_state_nxt = ST_APPLY;
          w_idx_nxt   = '0;
          w_acc_nxt   = '0;
          w_tmr_load  = 1'b1;
          w_tmr_val   = SETTLE_LD;
        end
      end

      default: begin
        w_state_nxt = ST_IDLE;
        w_idx_nxt   = '0;
        w_acc_nxt   = '0;
      end
    endcase
  end

  // Start edge register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_start_q <= 1'b0;
    end else begin
      r_start_q <= start;
    end
  end

  // FSM state, vector index and live mismatch accumulator
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_idx   <= '0;
      r_acc   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      r_acc   <= w_acc_nxt;
    end
  end

  // Verdict registers: only updated as a run completes, so the previous result stays lit during a run
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_pass  <= 1'b0;
      r_mask  <= '0;
    end else if (w_done_entry) begin
      r_valid <= 1'b1;
      r_pass  <= (r_acc == '0);
      r_mask  <= r_acc;
    end
  end

  assign gut_a            = r_idx[1];
  assign gut_b            = r_idx[0];
  assign led_vec          = r_idx;
  assign busy             = (r_state == ST_APPLY) || (r_state == ST_CHECK) || (r_state == ST_HOLD);
  assign result_valid     = r_valid;
  assign result_pass      = r_pass;
  assign result_fail_mask = r_mask;
  assign led_pass         = r_valid & r_pass;
  assign led_fail         = r_valid & ~r_pass;

endmodule

// File: tb/tb_gate_test_sequencer.sv
// Bench for gate_test_sequencer: one single-shot instance (AND table) and one free-running instance (NAND table).
// Latency: each run is predicted from the cycle arithmetic of settle/check/hold phases.
// Backpressure: n/a.
module tb_gate_test_sequencer;
  import gate_test_pkg::*;

  localparam int S    = 2;
  localparam int P    = 4;
  localparam int VLAT = S + 1 + P;      // cycles per vector
  localparam int RUN  = 4 * VLAT + 1;   // cycles per run incl. the DONE cycle

  logic clk;
  logic rst_n;
  logic sel;          // 0: single-shot instance, 1: continuous instance
  logic start_drv;
  logic gut_y;

  logic       a0, b0, busy0, valid0, pass0, lp0, lf0;
  logic [3:0] mask0;
  logic [1:0] vec0;
  logic       a1, b1, busy1, valid1, pass1, lp1, lf1;
  logic [3:0] mask1;
  logic [1:0] vec1;

  logic       start0, start1;
  logic       gut_a, gut_b, busy, r_valid_o, r_pass_o, led_pass, led_fail;
  logic [3:0] mask_o;
  logic [1:0] led_vec;

  assign start0 = sel ? 1'b0 : start_drv;
  assign start1 = sel ? start_drv : 1'b0;

  assign gut_a     = sel ? a1 : a0;
  assign gut_b     = sel ? b1 : b0;
  assign busy      = sel ? busy1 : busy0;
  assign r_valid_o = sel ? valid1 : valid0;
  assign r_pass_o  = sel ? pass1 : pass0;
  assign mask_o    = sel ? mask1 : mask0;
  assign led_pass  = sel ? lp1 : lp0;
  assign led_fail  = sel ? lf1 : lf0;
  assign led_vec   = sel ? vec1 : vec0;

  gate_test_sequencer #(
    .EXPECTED(TT_AND), .SETTLE_CYCLES(S), .STEP_CYCLES(P), .CONTINUOUS(1'b0)
  ) u_dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .gut_y(gut_y),
    .gut_a(a0), .gut_b(b0), .busy(busy0), .result_valid(valid0), .result_pass(pass0),
    .result_fail_mask(mask0), .led_pass(lp0), .led_fail(lf0), .led_vec(vec0)
  );

  gate_test_sequencer #(
    .EXPECTED(TT_NAND), .SETTLE_CYCLES(S), .STEP_CYCLES(P), .CONTINUOUS(1'b1)
  ) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .gut_y(gut_y),
    .gut_a(a1), .gut_b(b1), .busy(busy1), .result_valid(valid1), .result_pass(pass1),
    .result_fail_mask(mask1), .led_pass(lp1), .led_fail(lf1), .led_vec(vec1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference verdict as visible on the result outputs
  int         n_checks;
  int         n_errors;
  logic       m_valid;
  logic       m_pass;
  logic [3:0] m_mask;
  logic [1:0] m_idle_vec;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_outputs(input logic busy_e, input logic [1:0] vec_e);
    check_eq("busy", 32'(busy), 32'(busy_e));
    check_eq("gut_ab", 32'({gut_a, gut_b}), 32'(vec_e));
    check_eq("led_vec", 32'(led_vec), 32'(vec_e));
    check_eq("result_valid", 32'(r_valid_o), 32'(m_valid));
    check_eq("result_pass", 32'(r_pass_o), 32'(m_pass));
    check_eq("result_fail_mask", 32'(mask_o), 32'(m_mask));
    check_eq("led_pass", 32'(led_pass), 32'(m_valid & m_pass));
    check_eq("led_fail", 32'(led_fail), 32'(m_valid & ~m_pass));
  endtask

  task automatic clear_model();
    m_valid    = 1'b0;
    m_pass     = 1'b0;
    m_mask     = 4'b0000;
    m_idle_vec = 2'd0;
  endtask

  // Idle cycles: start level unchanged, noise on gut_y, nothing may move
  task automatic idle_check(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check_outputs(1'b0, m_idle_vec);
      gut_y = 1'($urandom);
    end
  endtask

  // gmode: 0 = gate matching the expected table, 1 = OR gate, 2 = random y at check time
  // smode: 0 = single start pulse, 1 = start held high, 2 = random start toggling during the run
  // force_run: run number whose vector 0 sees y stuck at 0 (-1 = none)
  // abort_at: cycle at which reset is pulsed mid-run (-1 = none)
  task automatic do_run(input int nruns, input int gmode, input int smode,
                        input int force_run, input int abort_at);
    logic [3:0] exp_tt;
    logic [3:0] or_tt;
    logic [3:0] acc;
    logic       y;
    int         p, v, r;
    exp_tt = sel ? TT_NAND : TT_AND;
    or_tt  = TT_OR;
    acc    = 4'b0000;
    @(negedge clk);
    start_drv = 1'b0;
    gut_y     = 1'($urandom);
    @(negedge clk);
    start_drv = 1'b1;
    gut_y     = 1'($urandom);
    for (int t = 0; t < nruns * RUN; t++) begin
      @(negedge clk);
      p = t % RUN;
      v = p / VLAT;
      r = p % VLAT;
      if (p == 0) acc = 4'b0000;
      if (p == RUN - 1) begin
        m_valid = 1'b1;
        m_mask  = acc;
        m_pass  = (acc == 4'b0000);
      end
      check_outputs(p < RUN - 1, (p < RUN - 1) ? 2'(v) : 2'd3);
      if (t == abort_at) begin
        start_drv = 1'b0;
        rst_n     = 1'b0;
        #1;
        clear_model();
        check_outputs(1'b0, 2'd0);
        @(negedge clk);
        rst_n = 1'b1;
        return;
      end
      y = 1'($urandom);
      if (p < RUN - 1 && r == S) begin
        case (gmode)
          0:       y = exp_tt[v];
          1:       y = or_tt[v];
          default: y = 1'($urandom);
        endcase
      end
      if (t / RUN == force_run && p < VLAT) y = 1'b0;
      if (p < RUN - 1 && r == S) acc[v] = y ^ exp_tt[v];
      gut_y = y;
      case (smode)
        0:       start_drv = 1'b0;
        1:       start_drv = 1'b1;
        default: start_drv = (p >= RUN - 3) ? 1'b1 : 1'($urandom);
      endcase
    end
    m_idle_vec = 2'd3;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    rst_n     = 1'b1;
    sel       = 1'b0;
    start_drv = 1'b0;
    gut_y     = 1'b0;
    clear_model();
    #2;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check_outputs(1'b0, 2'd0);
    rst_n = 1'b1;
    idle_check(3);

    // Matching AND gate -> pass
    do_run(1, 0, 0, -1, -1);
    idle_check(3);

    // OR gate against AND table -> vectors 1 and 2 mismatch
    do_run(1, 1, 0, -1, -1);
    idle_check(3);

    // Start held high: one run only, then a long idle with start still high
    do_run(1, 0, 1, -1, -1);
    idle_check(70);

    // Random y and random start chatter while busy; old verdict must stay until each DONE
    for (int k = 0; k < 4; k++) begin
      do_run(1, 2, 2, -1, -1);
      idle_check(2);
    end

    // Reset during the hold of vector 2, then a clean run
    do_run(1, 0, 0, -1, 2 * VLAT + S + 2);
    idle_check(5);
    do_run(1, 0, 0, -1, -1);
    idle_check(3);

    // Free-running NAND instance, vector 0 stuck low during the second run
    sel = 1'b1;
    clear_model();
    idle_check(2);
    do_run(3, 0, 0, 1, -1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/gate_test_sequencer.md
Name: gate_test_sequencer

Overview:
Self-checking sequencer for a two-input combinational gate-under-test (GUT) on the FPGA board. It replaces manual upload-and-inspect checks. On start it drives the four input vectors {a,b} = 00,01,10,11 in order, waits for settling, and samples the GUT output. It compares each sample against an expected truth table, paces each step so a human can follow it on the LEDs, and latches a pass/fail verdict on the board LEDs.

Parameters:
EXPECTED, 4'b1000, expected y per vector index {a,b}; bit i is the value for index i (default = AND)
SETTLE_CYCLES, 2, cycles vector is held before sampling y (>=1)
STEP_CYCLES, 12_000_000, display hold per vector after check (>=1; 1 s at 12 MHz)
CONTINUOUS, 0, 1 = auto-restart after each run; 0 = run once per start

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
start  in  1  synchronous level (debounced upstream); rising edge launches a run
gut_y  in  1  output of gate-under-test
gut_a  out  1  GUT input a (vector index bit 1)
gut_b  out  1  GUT input b (vector index bit 0)
busy  out  1  high while a run is in progress
result_valid  out  1  high once any run has completed since reset
result_pass  out  1  last completed run had zero mismatches
result_fail_mask  out  4  last completed run's per-vector mismatch bits
led_pass  out  1  result_valid & result_pass
led_fail  out  1  result_valid & ~result_pass
led_vec  out  2  current vector index, for display

Behaviour:
- Reset (async assert, sync deassert handled by the board reset logic): state IDLE, vector index 0, gut_a/gut_b 0, busy 0, result_valid 0, result_pass 0, result_fail_mask 0, live mismatch accumulator 0, timer 0, start edge register 0. Reset mid-run abandons the run with no verdict.
- start edge: start_q registered each cycle; launch = start & ~start_q. Launch is ignored unless the state is IDLE or DONE.
- States:
  - IDLE: on launch -> APPLY, index 0, accumulator cleared, timer loaded with SETTLE_CYCLES-1.
  - APPLY: gut_a/gut_b = index; count down; at timer 0 -> CHECK.
  - CHECK (1 cycle): accumulator[index] <= gut_y ^ EXPECTED[index]. -> HOLD with timer loaded STEP_CYCLES-1.
  - HOLD: vector still driven; at timer 0: if index < 3 -> APPLY with index+1 and timer reloaded SETTLE_CYCLES-1; if index == 3 -> DONE.
  - DONE (entry cycle): result_fail_mask <= final accumulator including the index-3 bit; result_pass <= (final mask == 0); result_valid <= 1. CONTINUOUS=1: next cycle -> APPLY as on launch. CONTINUOUS=0: stay until launch -> APPLY.
- busy = 1 in APPLY, CHECK and HOLD; 0 in IDLE and DONE.
- Per-vector latency is SETTLE_CYCLES + 1 + STEP_CYCLES cycles. A full run from the launch cycle to the DONE entry takes 1 + 4*(SETTLE_CYCLES+1+STEP_CYCLES) cycles.
- Result registers change only on DONE entry. They hold through subsequent runs, so LEDs show the previous verdict while busy.
- Index wrap: index never advances past 3. DONE resets it to 0 only on relaunch.
- gut_y is sampled only in CHECK. Glitches elsewhere are ignored.
- Timer width = clog2(max(SETTLE_CYCLES, STEP_CYCLES))+1 bits, unsigned, loaded value N-1, expiry when == 0.

Decomposition:
- Package gate_test_pkg: state encoding constants (IDLE, APPLY, CHECK, HOLD, DONE, 3-bit), VEC_W=2, NUM_VEC=4, truth-table constants TT_AND=4'b1000, TT_OR=4'b1110, TT_NAND=4'b0111, TT_NOR=4'b0001, TT_XOR=4'b0110.
- Sub-module step_timer: loadable down-counter with inputs load and load_value, output expired; reused by APPLY and HOLD.

Test Plan:
1. GUT = AND model, EXPECTED=TT_AND, SETTLE=2, STEP=4, start pulse -> vectors 00,01,10,11 each held 7 cycles; DONE entered 29 cycles after launch; result_pass=1, mask=0000, led_pass=1, led_fail=0.
2. GUT = OR model with EXPECTED=TT_AND -> mismatches at indices 1,2; mask=0110, result_pass=0, led_fail=1.
3. Start held high for 100 cycles -> exactly one run; second rising edge while busy ignored; new edge in DONE starts a run, and the old verdict stays visible until the new DONE.
4. rst_n low for 1 cycle during HOLD of index 2 -> all outputs 0 immediately (async); result_valid stays 0 until a full new run completes.
5. CONTINUOUS=1, GUT = NAND with EXPECTED=TT_NAND, start once -> busy drops for exactly 1 cycle every 29 cycles; result_pass=1 each run. Force gut_y=0 mid-second run at index 0 -> that run's mask=0001, result_pass=0.
6. gut_y toggled every cycle except in CHECK cycles (held correct) -> result_pass=1, proving only the CHECK-cycle sample is used.
